// File: rtl/key_debounce_cmd.sv
// Push-button front-end: 2-flop sync, shared ms prescaler and per-key
// debounce FSM emitting level plus press/release/long/repeat pulses.
module key_debounce_cmd #(
  parameter int KEY_W       = 5,
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] DB_END  = 16'(DEBOUNCE_MS - 1);
  localparam logic [15:0] LG_END  = 16'(LONG_MS - 1);
  localparam logic [15:0] RP_END  = 16'(REPEAT_MS - 1);

  typedef enum logic [2:0] {
    IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB
  } state_e;

  logic [KEY_W-1:0] s1_q, s2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;

  // Two-flop synchroniser; only s2_q feeds the key FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  assign tick = (pre_q == PRE_MAX);

  // Free-running ms prescaler, shared by all keys.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    state_e      st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lvl_q, lvl_d;
    logic        prs_q, prs_d;
    logic        rel_q, rel_d;
    logic        lng_q, lng_d;
    logic        rep_q, rep_d;
    logic        s;
    logic        db_hit, lg_hit, rp_hit;

    assign s      = s2_q[k];
    assign db_hit = tick && (cnt_q == DB_END);
    assign lg_hit = tick && (cnt_q == LG_END);
    assign rp_hit = tick && (cnt_q == RP_END);

    // State, ms counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        lng_q <= 1'b0;
        rep_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
        lng_q <= lng_d;
        rep_q <= rep_d;
      end
    end

    // Next state; a raw change wins over a coincident tick.
    always_comb begin
      st_d  = st_q;
      cnt_d = tick ? cnt_q + 16'd1 : cnt_q;
      unique case (st_q)
        IDLE: begin
          cnt_d = '0;
          if (s) st_d = PRESS_DB;
        end
        PRESS_DB: begin
          if (!s) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (db_hit) begin
            st_d  = HELD;
            cnt_d = '0;
          end
        end
        HELD: begin
          if (!s) begin
            st_d  = RELEASE_DB;
            cnt_d = '0;
          end else if (lg_hit) begin
            st_d  = LONG_HELD;
            cnt_d = '0;
          end
        end
        LONG_HELD: begin
          if (!s) begin
            st_d  = RELEASE_DB;
            cnt_d = '0;
          end else if (rp_hit) begin
            cnt_d = '0;
          end
        end
        RELEASE_DB: begin
          if (s) begin
            st_d  = HELD;
            cnt_d = '0;
          end else if (db_hit) begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    // Pulse and level decisions, registered one cycle later.
    always_comb begin
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
      lng_d = 1'b0;
      rep_d = 1'b0;
      unique case (st_q)
        PRESS_DB: begin
          if (s && db_hit) begin
            prs_d = 1'b1;
            lvl_d = 1'b1;
          end
        end
        HELD: begin
          if (s && lg_hit) lng_d = 1'b1;
        end
        LONG_HELD: begin
          if (s && rp_hit) rep_d = 1'b1;
        end
        RELEASE_DB: begin
          if (!s && db_hit) begin
            rel_d = 1'b1;
            lvl_d = 1'b0;
          end
        end
        default: begin
          lvl_d = lvl_q;
        end
      endcase
    end

    assign key_level[k]   = lvl_q;
    assign key_press[k]   = prs_q;
    assign key_release[k] = rel_q;
    assign key_long[k]    = lng_q;
    assign key_repeat[k]  = rep_q;
  end

endmodule

// File: tb/tb_key_debounce_cmd.sv
// Scoreboard bench for key_debounce_cmd: stimulus queues expected
// pulses, a negedge monitor pops and checks each pulse it sees.
module tb_key_debounce_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_raw = '0;
  logic [4:0] key_level, key_press, key_release;
  logic [4:0] key_long, key_repeat;

  key_debounce_cmd #(
    .KEY_W(5), .CLK_HZ(10_000), .DEBOUNCE_MS(4),
    .LONG_MS(20), .REPEAT_MS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 press, 1 release, 2 long, 3 repeat
  typedef struct {
    int key;
    int kind;
    bit rel;
    int lo;
    int hi;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int last_cyc[5];
  int press_cyc[5];

  function automatic string kname(int kind);
    case (kind)
      0: return "press";
      1: return "release";
      2: return "long";
      default: return "repeat";
    endcase
  endfunction

  task automatic push(int k, int kind, bit rel, int lo, int hi);
    exp_t e;
    e.key = k; e.kind = kind; e.rel = rel; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic chk(string nm, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(int bound);
    int t = 0;
    while (q.size() > 0 && t < bound) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("queue_drained", q.size(), 0, 0);
    q.delete();
    wait_clks(5);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_level"},   int'(key_level),   0, 0);
    chk({nm, "_press"},   int'(key_press),   0, 0);
    chk({nm, "_release"}, int'(key_release), 0, 0);
    chk({nm, "_long"},    int'(key_long),    0, 0);
    chk({nm, "_repeat"},  int'(key_repeat),  0, 0);
  endtask

  // Monitor: every observed pulse must match the queue head.
  always @(negedge clk) begin : mon
    logic [4:0] v [4];
    exp_t e;
    int lo, hi;
    if (rst_n) begin
      v[0] = key_press;
      v[1] = key_release;
      v[2] = key_long;
      v[3] = key_repeat;
      for (int kd = 0; kd < 4; kd++) begin
        for (int k = 0; k < 5; k++) begin
          if (v[kd][k]) begin
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected %s[%0d] at cyc %0d",
                       kname(kd), k, cyc);
            end else begin
              e = q.pop_front();
              if (e.key != k || e.kind != kd) begin
                tests++;
                fails++;
                $display("FAIL order: got %s[%0d], want %s[%0d]",
                         kname(kd), k, kname(e.kind), e.key);
              end else begin
                lo = e.rel ? last_cyc[k] + e.lo : e.lo;
                hi = e.rel ? last_cyc[k] + e.hi : e.hi;
                chk($sformatf("%s[%0d]_time", kname(kd), k),
                    cyc, lo, hi);
                chk($sformatf("%s[%0d]_level", kname(kd), k),
                    int'(key_level[k]), (kd != 1) ? 1 : 0,
                    (kd != 1) ? 1 : 0);
              end
              last_cyc[k] = cyc;
              if (kd == 0) press_cyc[k] = cyc;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int e, r, g, d;
    rst_n = 1'b0;
    key_raw = '0;
    wait_clks(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    wait_clks(5);

    // 1: clean press/release on key 1
    e = cyc;
    key_raw[1] = 1'b1;
    push(1, 0, 0, e + 32, e + 43);
    wait_clks(100);
    r = cyc;
    key_raw[1] = 1'b0;
    push(1, 1, 0, r + 34, r + 43);
    drain(80);

    // 2: bounce on key 0, last edge at i=8
    for (int i = 0; i < 9; i++) begin
      key_raw[0] = (i % 2 == 0);
      if (i < 8) wait_clks(7);
    end
    e = cyc;
    push(0, 0, 0, e + 32, e + 43);
    wait_clks(60);
    r = cyc;
    key_raw[0] = 1'b0;
    push(0, 1, 0, r + 34, r + 43);
    drain(80);

    // 3: long hold on key 2 with four repeats
    e = cyc;
    key_raw[2] = 1'b1;
    push(2, 0, 0, e + 32, e + 43);
    push(2, 2, 1, 200, 200);
    for (int i = 0; i < 4; i++) push(2, 3, 1, 50, 50);
    wait_clks(450);
    r = cyc;
    key_raw[2] = 1'b0;
    push(2, 1, 0, r + 34, r + 43);
    drain(80);

    // 4: 25-clk release glitch restarts the long timer
    e = cyc;
    key_raw[3] = 1'b1;
    push(3, 0, 0, e + 32, e + 43);
    wait_clks(100);
    key_raw[3] = 1'b0;
    wait_clks(25);
    key_raw[3] = 1'b1;
    g = cyc;
    chk("glitch_level3", int'(key_level[3]), 1, 1);
    push(3, 2, 0, g + 194, g + 203);
    wait_clks(220);
    r = cyc;
    key_raw[3] = 1'b0;
    push(3, 1, 0, r + 34, r + 43);
    drain(80);

    // 5: keys 0 and 4 on the same clk
    e = cyc;
    key_raw = key_raw | 5'b10001;
    push(0, 0, 0, e + 32, e + 43);
    push(4, 0, 0, e + 32, e + 43);
    wait_clks(60);
    r = cyc;
    key_raw = key_raw & 5'b01110;
    push(0, 1, 0, r + 34, r + 43);
    push(4, 1, 0, r + 34, r + 43);
    drain(80);
    chk("same_cycle_press_0_4", press_cyc[4] - press_cyc[0], 0, 0);

    // 6: reset while key 1 is in long-hold
    e = cyc;
    key_raw[1] = 1'b1;
    push(1, 0, 0, e + 32, e + 43);
    push(1, 2, 1, 200, 200);
    wait_clks(280);
    chk("pre_reset_queue", q.size(), 0, 0);
    chk("pre_reset_level1", int'(key_level[1]), 1, 1);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    wait_clks(3);
    rst_n = 1'b1;
    d = cyc;
    push(1, 0, 0, d + 40, d + 40);
    wait_clks(60);
    r = cyc;
    key_raw[1] = 1'b0;
    push(1, 1, 0, r + 34, r + 43);
    drain(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
